// File: rtl/bram_burst_reader_pkg.sv
// Shared types and elaboration helpers for the BRAM burst reader.
// Latency: none (package only).
// Backpressure: none (package only).
package bram_burst_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result = 0;
    int v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Read latency of the attached RAM for a given performance mode.
  function automatic int ramLatency(input string perf);
    return (perf == "HIGH_PERFORMANCE") ? 3 : 1;
  endfunction

endpackage

// File: rtl/bram_burst_reader_fifo.sv
// Register FIFO holding returned RAM words together with their last-beat flag.
// Latency: a word written in cycle N appears on rdDat in cycle N+1 (no fall-through).
// Backpressure: writer must respect count (credit source); rdVld holds until rdRdy.
module bram_burst_reader_fifo
  import bram_burst_reader_pkg::*;
#(
  parameter int C_WIDTH = 65,
  parameter int C_DEPTH = 4,
  localparam int CW = clog2(C_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrVld,
  input  logic [C_WIDTH-1:0] wrDat,
  output logic               rdVld,
  input  logic               rdRdy,
  output logic [C_WIDTH-1:0] rdDat,
  output logic [CW-1:0]      count
);

  localparam int PW = (clog2(C_DEPTH) < 1) ? 1 : clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;
  logic               doWr;
  logic               doRd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(C_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdVld = (count != '0);
  assign rdDat = mem[rdPtr];
  assign doRd  = rdVld & rdRdy;
  assign doWr  = wrVld & ((count != CW'(C_DEPTH)) | doRd);

  // Storage, pointers and occupancy; storage is cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < C_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doWr) begin
        mem[wrPtr] <= wrDat;
        wrPtr      <= bump(wrPtr);
      end
      if (doRd) rdPtr <= bump(rdPtr);
      count <= count + CW'(doWr) - CW'(doRd);
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read controller driving one port of a no-change BRAM, streaming words out.
// Latency: command in T, first read T+1, first beat T+2+L; one beat per cycle when unthrottled.
// Backpressure: reads issue only while in-flight + buffered < FIFO depth, so no word is lost.
module bram_burst_reader
  import bram_burst_reader_pkg::*;
#(
  parameter int    C_RAM_WIDTH  = 64,
  parameter int    C_RAM_DEPTH  = 512,
  parameter string C_RAM_PERF   = "LOW_LATENCY",
  parameter int    C_FIFO_DEPTH = 4,
  localparam int   AW = clog2(C_RAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [AW:0]            cmd_len,
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_rden,
  input  logic [C_RAM_WIDTH-1:0] ram_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [C_RAM_WIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  localparam int L  = ramLatency(C_RAM_PERF);
  localparam int CW = clog2(C_FIFO_DEPTH + 1);
  localparam int OW = clog2(C_FIFO_DEPTH + L + 1);

  // The FIFO must absorb every read already in the RAM pipeline plus one.
  if (C_FIFO_DEPTH < L + 1) begin : gBadDepth
    $error("bram_burst_reader: C_FIFO_DEPTH must be at least read latency + 1");
  end

  state_t               state;
  state_t               stateNext;
  logic [AW-1:0]        addrCnt;
  logic [AW:0]          remCnt;
  logic [L-1:0]         vldSr;
  logic [L-1:0]         lastSr;
  logic [CW-1:0]        fifoCount;
  logic [OW-1:0]        outstanding;
  logic [C_RAM_WIDTH:0] fifoRdDat;
  logic                 accept;
  logic                 issue;
  logic                 lastHs;
  logic                 doneR;

  assign outstanding = OW'($countones(vldSr)) + OW'(fifoCount);
  assign lastHs      = m_valid & m_ready & m_last;
  assign ram_addr    = addrCnt;
  assign ram_rden    = busy;
  assign done        = doneR;
  assign m_data      = fifoRdDat[C_RAM_WIDTH-1:0];
  assign m_last      = fifoRdDat[C_RAM_WIDTH];

  // Next state, command handshake and credit-gated read issue.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len != '0) stateNext = READ;
        end
      end
      READ: begin
        issue = (remCnt != '0) && (outstanding < OW'(C_FIFO_DEPTH));
        if (issue && remCnt == (AW+1)'(1)) stateNext = DRAIN;
      end
      DRAIN: begin
        if (lastHs) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register and the one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      doneR <= 1'b0;
    end else begin
      state <= stateNext;
      doneR <= (accept && cmd_len == '0) || (state == DRAIN && lastHs);
    end
  end

  // Address counter wraps at the top of the RAM; remaining count tracks reads left to issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addrCnt <= '0;
      remCnt  <= '0;
    end else if (accept) begin
      addrCnt <= cmd_addr;
      remCnt  <= cmd_len;
    end else if (issue) begin
      addrCnt <= (addrCnt == AW'(C_RAM_DEPTH - 1)) ? '0 : addrCnt + 1'b1;
      remCnt  <= remCnt - 1'b1;
    end
  end

  // Shadow the RAM pipeline so only cycles that issued a read are captured, with their last tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vldSr  <= '0;
      lastSr <= '0;
    end else begin
      vldSr[0]  <= issue;
      lastSr[0] <= issue && (remCnt == (AW+1)'(1));
      for (int i = 1; i < L; i++) begin
        vldSr[i]  <= vldSr[i-1];
        lastSr[i] <= lastSr[i-1];
      end
    end
  end

  bram_burst_reader_fifo #(
    .C_WIDTH (C_RAM_WIDTH + 1),
    .C_DEPTH (C_FIFO_DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wrVld (vldSr[L-1]),
    .wrDat ({lastSr[L-1], ram_dout}),
    .rdVld (m_valid),
    .rdRdy (m_ready),
    .rdDat (fifoRdDat),
    .count (fifoCount)
  );

endmodule

// File: tb/tb_bram_burst_reader.sv
// Bench for bram_burst_reader: one low-latency and one high-performance instance, each with a RAM model.
// Latency: n/a.
// Backpressure: m_ready is driven per test (steady high or 1-of-4 toggling).
module tb_bram_burst_reader;

  localparam int W     = 64;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int FD    = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFails  = 0;

  logic [W-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chkLe(input string name, input int act, input int lim);
    nChecks++;
    if (act > lim) begin
      nFails++;
      $display("FAIL %s: got %0d, limit %0d (cycle %0d)", name, act, lim, cyc);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int L = (g == 0) ? 1 : 3;

    logic          rstN     = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [AW-1:0] cmdAddr  = '0;
    logic [AW:0]   cmdLen   = '0;
    logic [AW-1:0] ramAddr;
    logic          ramRden;
    logic [W-1:0]  ramDout;
    logic          mValid;
    logic          mReady   = 1'b0;
    logic [W-1:0]  mData;
    logic          mLast;
    logic          busy;
    logic          done;
    logic          fin      = 1'b0;

    if (g == 0) begin : gLL
      bram_burst_reader #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(DEPTH), .C_RAM_PERF("LOW_LATENCY"),
                          .C_FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rstN), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
        .cmd_addr(cmdAddr), .cmd_len(cmdLen), .ram_addr(ramAddr), .ram_rden(ramRden),
        .ram_dout(ramDout), .m_valid(mValid), .m_ready(mReady), .m_data(mData),
        .m_last(mLast), .busy(busy), .done(done));
    end else begin : gHP
      bram_burst_reader #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(DEPTH), .C_RAM_PERF("HIGH_PERFORMANCE"),
                          .C_FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rstN), .cmd_valid(cmdValid), .cmd_ready(cmdReady),
        .cmd_addr(cmdAddr), .cmd_len(cmdLen), .ram_addr(ramAddr), .ram_rden(ramRden),
        .ram_dout(ramDout), .m_valid(mValid), .m_ready(mReady), .m_data(mData),
        .m_last(mLast), .busy(busy), .done(done));
    end

    // RAM read pipeline: every stage advances only while rden is high.
    logic [W-1:0] p1, p2, p3;
    always @(posedge clk) begin
      if (ramRden) begin
        p1 <= mem[ramAddr];
        p2 <= p1;
        p3 <= p2;
      end
    end
    assign ramDout = (L == 1) ? p1 : p3;

    // Model state: expected beats, whether a burst is running, expected done.
    beat_t expQ[$];
    logic         active    = 1'b0;
    logic         expDone   = 1'b0;
    logic         nextDone  = 1'b0;
    logic         stallPrev = 1'b0;
    logic [W-1:0] prevData  = '0;
    logic         prevLast  = 1'b0;
    int tAccept = 0, popped = 0, startAddr = 0, outs = 0;
    int nBeats = 0, nLast = 0, maxOuts = 0;
    int firstHs = -1, lastHs = -1, rdenFirst = -1, rdenLast = -1, doneCyc = -1;
    int addrLog [8];
    int tCmd = 0;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
      if (!rstN) begin
        expQ.delete();
        active    = 1'b0;
        expDone   = 1'b0;
        stallPrev = 1'b0;
      end else begin
        nextDone = 1'b0;
        chk("done", done, expDone);
        chk("busy", busy, active);
        chk("ram_rden", ramRden, active);
        chk("cmd_ready", cmdReady, !active);
        if (done) doneCyc = cyc;
        if (ramRden) begin
          if (rdenFirst < 0) rdenFirst = cyc;
          rdenLast = cyc;
        end
        if (cyc - tAccept >= 1 && cyc - tAccept <= 7) addrLog[cyc - tAccept] = int'(ramAddr);
        if (active) begin
          outs = ((int'(ramAddr) - startAddr) & (DEPTH - 1)) - popped;
          chkLe("outstanding", outs, FD);
          if (outs > maxOuts) maxOuts = outs;
        end
        if (stallPrev) begin
          chk("stall valid hold", mValid, 1);
          chk("stall data hold", mData, prevData);
          chk("stall last hold", mLast, prevLast);
        end
        if (mValid) begin
          if (expQ.size() == 0) begin
            chk("unexpected beat", mValid, 0);
          end else begin
            chk("m_data", mData, expQ[0].d);
            chk("m_last", mLast, expQ[0].l);
            if (mReady) begin
              if (firstHs < 0) firstHs = cyc;
              lastHs = cyc;
              nBeats++;
              popped++;
              if (expQ[0].l) begin
                nLast++;
                active   = 1'b0;
                nextDone = 1'b1;
              end
              void'(expQ.pop_front());
            end
          end
        end
        stallPrev = mValid && !mReady;
        prevData  = mData;
        prevLast  = mLast;
        if (cmdValid && cmdReady) begin
          tAccept   = cyc;
          popped    = 0;
          startAddr = int'(cmdAddr);
          firstHs   = -1; lastHs = -1; rdenFirst = -1; rdenLast = -1; doneCyc = -1;
          nBeats    = 0;  nLast  = 0;  maxOuts   = 0;
          if (cmdLen == '0) begin
            nextDone = 1'b1;
          end else begin
            active = 1'b1;
            for (int i = 0; i < int'(cmdLen); i++)
              expQ.push_back('{mem[(int'(cmdAddr) + i) % DEPTH], (i == int'(cmdLen) - 1)});
          end
        end
        expDone = nextDone;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic sendCmd(input int a, input int n);
      cmdAddr  = AW'(a);
      cmdLen   = (AW+1)'(n);
      cmdValid = 1'b1;
      tCmd     = cyc;
      tick();
      cmdValid = 1'b0;
    endtask

    task automatic waitDone(input string name);
      int n = 0;
      while (doneCyc < 0 && n < 300) begin
        tick();
        n++;
      end
      if (doneCyc < 0) chk({name, " done timeout"}, 0, 1);
    endtask

    task automatic checkResetVals(input string tag);
      chk({tag, " cmd_ready"}, cmdReady, 1);
      chk({tag, " m_valid"}, mValid, 0);
      chk({tag, " m_last"}, mLast, 0);
      chk({tag, " m_data"}, mData, 0);
      chk({tag, " ram_rden"}, ramRden, 0);
      chk({tag, " ram_addr"}, ramAddr, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
    endtask

    // Directed sequence for this instance.
    initial begin
      int n;
      tick();
      tick();
      checkResetVals("reset");
      rstN = 1'b1;
      tick();

      // Basic burst: addr 10, 4 words, no backpressure.
      mReady = 1'b1;
      sendCmd(10, 4);
      waitDone("basic");
      chk("basic first beat cycle", firstHs, tCmd + ((g == 0) ? 3 : 5));
      chk("basic last beat cycle", lastHs, tCmd + ((g == 0) ? 6 : 8));
      chk("basic done cycle", doneCyc, tCmd + ((g == 0) ? 7 : 9));
      chk("basic beats", nBeats, 4);
      chk("basic last count", nLast, 1);
      chk("basic rden first", rdenFirst, tCmd + 1);
      chk("basic rden last", rdenLast, tCmd + ((g == 0) ? 6 : 8));
      tick();

      // Address wrap at the top of the RAM.
      sendCmd(510, 4);
      waitDone("wrap");
      chk("wrap addr 0", addrLog[1], 510);
      chk("wrap addr 1", addrLog[2], 511);
      chk("wrap addr 2", addrLog[3], 0);
      chk("wrap addr 3", addrLog[4], 1);
      chk("wrap beats", nBeats, 4);
      tick();

      // Zero-length command.
      sendCmd(33, 0);
      chk("len0 cmd_ready", cmdReady, 1);
      waitDone("len0");
      chk("len0 done cycle", doneCyc, tCmd + 1);
      chk("len0 beats", nBeats, 0);
      chk("len0 rden", rdenFirst, -1);
      tick();

      if (g == 1) begin
        // 16 words under heavy backpressure: ready one cycle in four.
        sendCmd(20, 16);
        n = 0;
        while (doneCyc < 0 && n < 400) begin
          mReady = (n % 4 == 0);
          tick();
          n++;
        end
        if (doneCyc < 0) chk("stall done timeout", 0, 1);
        mReady = 1'b1;
        chk("stall beats", nBeats, 16);
        chk("stall last count", nLast, 1);
        chk("stall peak outstanding", maxOuts, FD);
      end else begin
        // Reset in the middle of an 8-word burst, then a fresh burst.
        sendCmd(200, 8);
        n = 0;
        while (nBeats < 3 && n < 50) begin
          tick();
          n++;
        end
        if (nBeats < 3) chk("midrst beat timeout", nBeats, 3);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkResetVals("midrst");
        repeat (6) tick();
        sendCmd(100, 2);
        waitDone("after reset");
        chk("after reset beats", nBeats, 2);
        chk("after reset first beat", firstHs, tCmd + 3);
      end
      repeat (3) tick();
      fin = 1'b1;
    end
  end

  // Wait for both instances, bounded, then report.
  initial begin
    int n = 0;
    while (!(gInst[0].fin && gInst[1].fin) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (!(gInst[0].fin && gInst[1].fin)) chk("global timeout", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
